// File: rtl/gnrl_bus_mux_pkg.sv
// Shared definitions for the bus mux: master count, one-hot state encoding
// and helpers for sizing the packed per-master payload slices.
package gnrl_bus_mux_pkg;

   localparam int N_MST = 3;

   // Bit positions of the one-hot state vector.
   localparam int ST_IDLE_IDX  = 0;
   localparam int ST_ISSUE_IDX = 1;
   localparam int ST_WAIT_IDX  = 2;
   localparam int ST_DONE_IDX  = 3;

   typedef enum logic [3:0] {
      ST_IDLE     = 4'b0001,
      ST_ISSUE    = 4'b0010,
      ST_WAIT_RSP = 4'b0100,
      ST_DONE     = 4'b1000
   } state_e;

   // Byte-enable width for a given data width.
   function automatic int mask_w(input int dw);
      return dw / 8;
   endfunction

   // One master's payload slice: {addr, wdata, wmask, wen}.
   function automatic int payload_w(input int aw, input int dw);
      return aw + dw + dw / 8 + 1;
   endfunction

   // True when exactly one bit of the grant vector is set.
   function automatic logic is_onehot(input logic [N_MST-1:0] v);
      return (v != '0) && ((v & (v - N_MST'(1))) == '0);
   endfunction

endpackage

// File: rtl/gnrl_dffr.sv
// Plain D flop with asynchronous active-low reset to a parameterised value.
module gnrl_dffr #(
   parameter int            DW      = 1,
   parameter logic [DW-1:0] RST_VAL = '0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [DW-1:0] d,
   output logic [DW-1:0] q
);

   // Register d every rising edge; reset forces RST_VAL immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking assignment so every flop samples pre-edge values.
      if (!rst_n) q <= RST_VAL;
      else        q <= d;
   end

endmodule

// File: rtl/gnrl_onehot_mux.sv
// AND-OR selector: picks the slice of din whose sel bit is set.
// A zero sel yields zero; callers only use the result with a one-hot sel.
module gnrl_onehot_mux #(
   parameter int N = 3,
   parameter int W = 8
) (
   input  logic [N-1:0]   sel,
   input  logic [N*W-1:0] din,
   output logic [W-1:0]   dout
);

   // OR together every slice masked by its select bit.
   always_comb begin
      dout = '0;
      for (int i = 0; i < N; i++) begin
         dout = dout | (din[i*W +: W] & {W{sel[i]}});
      end
   end

endmodule

// File: rtl/gnrl_bus_mux.sv
// Shared-slave bus mux sitting behind the 3-way round-robin arbiter.
// Latches the granted master's command, issues it to the slave, routes the
// response back to the owner and holds end_access high while the bus is owned.
module gnrl_bus_mux
   import gnrl_bus_mux_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [N_MST-1:0]                  i_gnt_vec,
   input  logic [N_MST-1:0]                  i_m_vld,
   input  logic [N_MST*ADDR_WIDTH-1:0]       i_m_addr,
   input  logic [N_MST*DATA_WIDTH-1:0]       i_m_wdata,
   input  logic [N_MST*(DATA_WIDTH/8)-1:0]   i_m_wmask,
   input  logic [N_MST-1:0]                  i_m_wen,
   output logic [N_MST-1:0]                  o_m_cmd_acc,
   output logic [N_MST-1:0]                  o_m_rsp_vld,
   output logic [DATA_WIDTH-1:0]             o_m_rdata,
   output logic                              o_m_rsp_err,
   output logic [N_MST-1:0]                  o_end_access_vec,
   output logic                              o_s_cmd_vld,
   input  logic                              i_s_cmd_rdy,
   output logic [ADDR_WIDTH-1:0]             o_s_addr,
   output logic [DATA_WIDTH-1:0]             o_s_wdata,
   output logic [DATA_WIDTH/8-1:0]           o_s_wmask,
   output logic                              o_s_wen,
   input  logic                              i_s_rsp_vld,
   input  logic [DATA_WIDTH-1:0]             i_s_rdata,
   input  logic                              i_s_rsp_err
);

   localparam int MW = mask_w(DATA_WIDTH);
   localparam int PW = payload_w(ADDR_WIDTH, DATA_WIDTH);

   logic [3:0]            state_q,   state_d;
   logic [N_MST-1:0]      owner_q,   owner_d;
   logic [PW-1:0]         payload_q, payload_d;
   logic [N_MST-1:0]      cmd_acc_q, cmd_acc_d;
   logic [N_MST-1:0]      end_acc_q, end_acc_d;
   logic [N_MST-1:0]      rsp_vld_q, rsp_vld_d;
   logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;
   logic                  err_q,     err_d;

   logic [N_MST*PW-1:0]   pl_vec;
   logic [PW-1:0]         pl_sel;
   logic                  take;

   // Regroup the per-field packed buses into one payload slice per master.
   for (genvar g = 0; g < N_MST; g++) begin : g_pack
      assign pl_vec[g*PW +: PW] = {i_m_addr[g*ADDR_WIDTH +: ADDR_WIDTH],
                                   i_m_wdata[g*DATA_WIDTH +: DATA_WIDTH],
                                   i_m_wmask[g*MW +: MW],
                                   i_m_wen[g]};
   end

   gnrl_onehot_mux #(.N(N_MST), .W(PW)) u_pl_mux (
      .sel  (i_gnt_vec),
      .din  (pl_vec),
      .dout (pl_sel)
   );

   // A grant is usable only in IDLE, when legal and backed by a valid command.
   assign take = state_q[ST_IDLE_IDX] && is_onehot(i_gnt_vec) && ((i_gnt_vec & i_m_vld) != '0);

   // Next-state and next-output logic for the four-state transaction FSM.
   always_comb begin
      // NOTE: every target gets a default first so no path infers a latch.
      state_d   = state_q;
      owner_d   = owner_q;
      payload_d = payload_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      cmd_acc_d = '0;
      end_acc_d = '0;
      rsp_vld_d = '0;
      case (1'b1)
         state_q[ST_IDLE_IDX]: begin
            if (take) begin
               state_d   = ST_ISSUE;
               owner_d   = i_gnt_vec;
               payload_d = pl_sel;
               cmd_acc_d = i_gnt_vec;
               end_acc_d = i_gnt_vec;
            end
         end
         state_q[ST_ISSUE_IDX]: begin
            end_acc_d = owner_q;
            if (i_s_cmd_rdy) state_d = ST_WAIT_RSP;
         end
         state_q[ST_WAIT_IDX]: begin
            if (i_s_rsp_vld) begin
               state_d   = ST_DONE;
               rsp_vld_d = owner_q;
               rdata_d   = i_s_rdata;
               err_d     = i_s_rsp_err;
            end else begin
               end_acc_d = owner_q;
            end
         end
         state_q[ST_DONE_IDX]: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   gnrl_dffr #(.DW(4), .RST_VAL(ST_IDLE)) u_state_ff (
      .clk(clk), .rst_n(rst_n), .d(state_d), .q(state_q));
   gnrl_dffr #(.DW(N_MST)) u_owner_ff (
      .clk(clk), .rst_n(rst_n), .d(owner_d), .q(owner_q));
   gnrl_dffr #(.DW(PW)) u_payload_ff (
      .clk(clk), .rst_n(rst_n), .d(payload_d), .q(payload_q));
   gnrl_dffr #(.DW(N_MST)) u_cmd_acc_ff (
      .clk(clk), .rst_n(rst_n), .d(cmd_acc_d), .q(cmd_acc_q));
   gnrl_dffr #(.DW(N_MST)) u_end_acc_ff (
      .clk(clk), .rst_n(rst_n), .d(end_acc_d), .q(end_acc_q));
   gnrl_dffr #(.DW(N_MST)) u_rsp_vld_ff (
      .clk(clk), .rst_n(rst_n), .d(rsp_vld_d), .q(rsp_vld_q));
   gnrl_dffr #(.DW(DATA_WIDTH)) u_rdata_ff (
      .clk(clk), .rst_n(rst_n), .d(rdata_d), .q(rdata_q));
   gnrl_dffr #(.DW(1)) u_err_ff (
      .clk(clk), .rst_n(rst_n), .d(err_d), .q(err_q));

   assign o_m_cmd_acc      = cmd_acc_q;
   assign o_m_rsp_vld      = rsp_vld_q;
   assign o_m_rdata        = rdata_q;
   assign o_m_rsp_err      = err_q;
   assign o_end_access_vec = end_acc_q;
   assign o_s_cmd_vld      = state_q[ST_ISSUE_IDX];
   assign {o_s_addr, o_s_wdata, o_s_wmask, o_s_wen} = payload_q;

endmodule

// File: tb/tb_gnrl_bus_mux.sv
// Self-checking bench for gnrl_bus_mux: directed scenarios, randomized
// transactions with random stalls, reset mid-flight, and a behavioural
// round-robin arbiter driving the grant.
module tb_gnrl_bus_mux;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int MW = DW / 8;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [2:0]      i_gnt_vec;
   logic [2:0]      i_m_vld;
   logic [3*AW-1:0] i_m_addr;
   logic [3*DW-1:0] i_m_wdata;
   logic [3*MW-1:0] i_m_wmask;
   logic [2:0]      i_m_wen;
   logic [2:0]      o_m_cmd_acc;
   logic [2:0]      o_m_rsp_vld;
   logic [DW-1:0]   o_m_rdata;
   logic            o_m_rsp_err;
   logic [2:0]      o_end_access_vec;
   logic            o_s_cmd_vld;
   logic            i_s_cmd_rdy;
   logic [AW-1:0]   o_s_addr;
   logic [DW-1:0]   o_s_wdata;
   logic [MW-1:0]   o_s_wmask;
   logic            o_s_wen;
   logic            i_s_rsp_vld;
   logic [DW-1:0]   i_s_rdata;
   logic            i_s_rsp_err;

   // Master-side payload model, one entry per master.
   logic [AW-1:0] m_addr  [3];
   logic [DW-1:0] m_wdata [3];
   logic [MW-1:0] m_wmask [3];
   logic          m_wen   [3];

   logic [2:0] gnt_drv;
   logic [2:0] arb_gnt;
   logic       arb_en;
   int         arb_last;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_pack
      assign i_m_addr[g*AW +: AW]  = m_addr[g];
      assign i_m_wdata[g*DW +: DW] = m_wdata[g];
      assign i_m_wmask[g*MW +: MW] = m_wmask[g];
      assign i_m_wen[g]            = m_wen[g];
   end

   assign i_gnt_vec = arb_en ? arb_gnt : gnt_drv;

   gnrl_bus_mux #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .i_gnt_vec        (i_gnt_vec),
      .i_m_vld          (i_m_vld),
      .i_m_addr         (i_m_addr),
      .i_m_wdata        (i_m_wdata),
      .i_m_wmask        (i_m_wmask),
      .i_m_wen          (i_m_wen),
      .o_m_cmd_acc      (o_m_cmd_acc),
      .o_m_rsp_vld      (o_m_rsp_vld),
      .o_m_rdata        (o_m_rdata),
      .o_m_rsp_err      (o_m_rsp_err),
      .o_end_access_vec (o_end_access_vec),
      .o_s_cmd_vld      (o_s_cmd_vld),
      .i_s_cmd_rdy      (i_s_cmd_rdy),
      .o_s_addr         (o_s_addr),
      .o_s_wdata        (o_s_wdata),
      .o_s_wmask        (o_s_wmask),
      .o_s_wen          (o_s_wen),
      .i_s_rsp_vld      (i_s_rsp_vld),
      .i_s_rdata        (i_s_rdata),
      .i_s_rsp_err      (i_s_rsp_err)
   );

   // First requester after the last served master, in rotation order.
   function automatic logic [2:0] rr_pick(input int last, input logic [2:0] req);
      logic [2:0] r;
      r = '0;
      for (int k = 1; k <= 3; k++) begin
         int c;
         c = (last + k) % 3;
         if (req[c] && r == '0) r = 3'b001 << c;
      end
      return r;
   endfunction

   function automatic int oh_idx(input logic [2:0] v);
      return v[2] ? 2 : (v[1] ? 1 : 0);
   endfunction

   // Behavioural arbiter: holds while the bus is owned, rotates otherwise.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         arb_gnt  <= '0;
         arb_last <= 2;
      end else if (arb_en) begin
         if (o_m_cmd_acc != '0)           arb_last <= oh_idx(o_m_cmd_acc);
         else if (o_end_access_vec == '0) arb_gnt  <= rr_pick(arb_last, i_m_vld);
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic randomize_payload();
      for (int i = 0; i < 3; i++) begin
         m_addr[i]  = $urandom;
         m_wdata[i] = $urandom;
         m_wmask[i] = MW'($urandom);
         m_wen[i]   = 1'($urandom);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full transaction for master m. Caller prepares the payload arrays.
   // Starts in an IDLE cycle, returns in the IDLE cycle after DONE, with
   // gnt_after/vld_after presented during DONE and that IDLE cycle.
   task automatic run_txn(input int m, input int rdy_wait, input int rsp_wait,
                          input logic [2:0] gnt_mid, input logic [2:0] vld_mid,
                          input logic [2:0] gnt_after, input logic [2:0] vld_after,
                          input logic [DW-1:0] rd, input logic er);
      logic [2:0]    own;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      logic [MW-1:0] em;
      logic          ew;
      int            cyc;
      int            n;
      own = 3'b001 << m;
      ea = m_addr[m]; ed = m_wdata[m]; em = m_wmask[m]; ew = m_wen[m];
      gnt_drv     = own;
      i_m_vld     = own | 3'($urandom_range(0, 7));
      i_s_cmd_rdy = 1'b0;
      i_s_rsp_vld = 1'b0;
      tick(); cyc = 1;
      check("cmd_acc", 64'(o_m_cmd_acc), 64'(own));
      check("s_cmd_vld", 64'(o_s_cmd_vld), 64'd1);
      check("end_access_c1", 64'(o_end_access_vec), 64'(own));
      check("s_addr", 64'(o_s_addr), 64'(ea));
      check("s_wdata", 64'(o_s_wdata), 64'(ed));
      check("s_wmask", 64'(o_s_wmask), 64'(em));
      check("s_wen", 64'(o_s_wen), 64'(ew));
      // Masters advance to new commands; the grant may wander.
      randomize_payload();
      gnt_drv = gnt_mid;
      i_m_vld = vld_mid;
      for (int k = 0; k < rdy_wait; k++) begin
         tick(); cyc++;
         check("stall_cmd_vld", 64'(o_s_cmd_vld), 64'd1);
         check("stall_addr", 64'(o_s_addr), 64'(ea));
         check("stall_wdata", 64'(o_s_wdata), 64'(ed));
         check("stall_cmd_acc", 64'(o_m_cmd_acc), 64'd0);
      end
      i_s_cmd_rdy = 1'b1;
      tick(); cyc++;
      i_s_cmd_rdy = 1'b0;
      check("cmd_vld_drop", 64'(o_s_cmd_vld), 64'd0);
      check("end_access_wait", 64'(o_end_access_vec), 64'(own));
      for (int k = 0; k < rsp_wait; k++) begin
         tick(); cyc++;
         check("wait_rsp_vld", 64'(o_m_rsp_vld), 64'd0);
         check("wait_end_access", 64'(o_end_access_vec), 64'(own));
      end
      i_s_rsp_vld = 1'b1;
      i_s_rdata   = rd;
      i_s_rsp_err = er;
      n = 0;
      do begin
         tick(); cyc++; n++;
         i_s_rsp_vld = 1'b0;
         i_s_rdata   = $urandom;
         i_s_rsp_err = 1'($urandom);
      end while (o_m_rsp_vld == '0 && n < 8);
      check("rsp_latency", 64'(cyc), 64'(3 + rdy_wait + rsp_wait));
      check("rsp_owner", 64'(o_m_rsp_vld), 64'(own));
      check("rsp_rdata", 64'(o_m_rdata), 64'(rd));
      check("rsp_err", 64'(o_m_rsp_err), 64'(er));
      check("end_access_done", 64'(o_end_access_vec), 64'd0);
      gnt_drv = gnt_after;
      i_m_vld = vld_after;
      tick();
      check("done_no_acc", 64'(o_m_cmd_acc), 64'd0);
      check("done_no_cmd", 64'(o_s_cmd_vld), 64'd0);
      check("rsp_one_pulse", 64'(o_m_rsp_vld), 64'd0);
   endtask

   initial begin
      logic [DW-1:0] rd;
      int            exp_idx;
      int            n;
      rst_n       = 1'b0;
      arb_en      = 1'b0;
      gnt_drv     = '0;
      i_m_vld     = '0;
      i_s_cmd_rdy = 1'b0;
      i_s_rsp_vld = 1'b0;
      i_s_rdata   = '0;
      i_s_rsp_err = 1'b0;
      randomize_payload();
      repeat (3) tick();
      check("reset_ctl", 64'({o_m_cmd_acc, o_m_rsp_vld, o_m_rsp_err, o_end_access_vec, o_s_cmd_vld}), 64'd0);
      check("reset_payload", 64'({o_s_addr, o_s_wdata}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Single read from master 1.
      randomize_payload();
      m_addr[1] = 32'h100;
      m_wen[1]  = 1'b0;
      run_txn(1, 0, 0, 3'b010, 3'b000, 3'b000, 3'b000, 32'hDEADBEEF, 1'b0);

      // Write from master 0 with command and response stalls.
      randomize_payload();
      m_wdata[0] = 32'h12345678;
      m_wmask[0] = 4'b0011;
      m_wen[0]   = 1'b1;
      run_txn(0, 3, 2, 3'b001, 3'b000, 3'b000, 3'b000, $urandom, 1'b1);

      // Grant moves to master 2 mid-transaction; master 2 served after DONE.
      randomize_payload();
      run_txn(0, 1, 1, 3'b100, 3'b100, 3'b100, 3'b100, 32'hA5A5_0001, 1'b0);
      tick();
      check("late_grant_acc", 64'(o_m_cmd_acc), 64'b100);
      check("late_grant_addr", 64'(o_s_addr), 64'(m_addr[2]));
      i_m_vld = '0;
      gnt_drv = '0;
      i_s_cmd_rdy = 1'b1;
      tick();
      i_s_cmd_rdy = 1'b0;
      i_s_rsp_vld = 1'b1;
      i_s_rdata   = 32'hC0DE_0002;
      tick();
      i_s_rsp_vld = 1'b0;
      check("late_grant_rsp", 64'(o_m_rsp_vld), 64'b100);
      check("late_grant_rdata", 64'(o_m_rdata), 64'hC0DE_0002);
      tick();

      // Illegal grants leave the block idle.
      gnt_drv = 3'b011; i_m_vld = 3'b011;
      repeat (2) tick();
      check("multi_grant_cmd", 64'(o_s_cmd_vld), 64'd0);
      check("multi_grant_acc", 64'(o_m_cmd_acc), 64'd0);
      gnt_drv = 3'b100; i_m_vld = 3'b011;
      repeat (2) tick();
      check("novld_grant_cmd", 64'(o_s_cmd_vld), 64'd0);
      check("novld_grant_acc", 64'(o_m_cmd_acc), 64'd0);
      check("novld_end_access", 64'(o_end_access_vec), 64'd0);
      gnt_drv = 3'b000; i_m_vld = 3'b111;
      repeat (2) tick();
      check("zero_grant_cmd", 64'(o_s_cmd_vld), 64'd0);

      // Reset while waiting for the response.
      randomize_payload();
      gnt_drv = 3'b010; i_m_vld = 3'b010; i_s_cmd_rdy = 1'b1;
      tick();
      i_m_vld = '0; gnt_drv = '0;
      tick();
      i_s_cmd_rdy = 1'b0;
      check("pre_reset_owner", 64'(o_end_access_vec), 64'b010);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_ctl", 64'({o_m_cmd_acc, o_m_rsp_vld, o_m_rsp_err, o_end_access_vec, o_s_cmd_vld, o_s_wen, o_s_wmask}), 64'd0);
      check("async_rst_addr", 64'(o_s_addr), 64'd0);
      check("async_rst_wdata", 64'(o_s_wdata), 64'd0);
      check("async_rst_rdata", 64'(o_m_rdata), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      i_s_rsp_vld = 1'b1;
      i_s_rdata   = 32'hBAD0_BAD0;
      tick();
      i_s_rsp_vld = 1'b0;
      check("stale_rsp_ignored", 64'(o_m_rsp_vld), 64'd0);
      check("stale_rsp_idle", 64'({o_s_cmd_vld, o_end_access_vec}), 64'd0);
      randomize_payload();
      run_txn(2, 0, 1, 3'b000, 3'b000, 3'b000, 3'b000, 32'h0F0F_1234, 1'b0);

      // Randomized transactions with random stalls and grant noise.
      for (int t = 0; t < 24; t++) begin
         randomize_payload();
         run_txn($urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 3),
                 3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
                 $urandom, 1'($urandom));
      end

      // Round robin with the arbiter in the loop and all masters valid.
      gnt_drv     = '0;
      i_m_vld     = 3'b111;
      i_s_cmd_rdy = 1'b1;
      arb_en      = 1'b1;
      exp_idx     = 0;
      for (int t = 0; t < 6; t++) begin
         n = 0;
         do begin
            tick(); n++;
         end while (o_m_cmd_acc == '0 && n < 20);
         check("rr_grant", 64'(o_m_cmd_acc), 64'(3'b001 << exp_idx));
         check("rr_addr", 64'(o_s_addr), 64'(m_addr[exp_idx]));
         m_addr[exp_idx] = $urandom;
         rd = $urandom;
         tick();
         i_s_rsp_vld = 1'b1;
         i_s_rdata   = rd;
         i_s_rsp_err = 1'b0;
         tick();
         i_s_rsp_vld = 1'b0;
         check("rr_rsp_owner", 64'(o_m_rsp_vld), 64'(3'b001 << exp_idx));
         check("rr_rdata", 64'(o_m_rdata), 64'(rd));
         exp_idx = (exp_idx + 1) % 3;
      end
      arb_en = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
